// File: rtl/uart_rx_pkg.sv
// Shared UART receive-side definitions: FSM states, parity convention and default frame width.
// The parity constants and the expected-bit helper are the same ones the TX generator uses.
package uart_rx_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Even: parity bit equals XOR of the data; odd: its complement.
  function automatic logic expected_par_bit(input logic acc, input logic par_type);
    return (par_type == PAR_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// Sampler-side strobe/bit/config inputs and per-frame result outputs of the RX frame checker.
interface uart_rx_frame_check_if #(
  parameter int unsigned WIDTH = uart_rx_pkg::DEFAULT_WIDTH
);
  logic             bit_strobe;
  logic             rx_bit;
  logic             par_en;
  logic             par_type;
  logic [WIDTH-1:0] p_data;
  logic             data_valid;
  logic             par_err;
  logic             stp_err;
  logic             busy;

  modport master (
    output bit_strobe, rx_bit, par_en, par_type,
    input  p_data, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  bit_strobe, rx_bit, par_en, par_type,
    output p_data, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_par_chk.sv
// Running-XOR parity accumulator for one received frame; flags a parity-bit mismatch.
module uart_rx_par_chk
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_accum,
  input  logic i_check,
  input  logic i_bit,
  input  logic i_par_type,
  output logic o_par_fail
);

  logic r_acc;
  logic r_par_fail;
  logic w_expected;

  assign w_expected = expected_par_bit(r_acc, i_par_type);

  // Accumulate data bits, then compare the parity bit against the expected value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc      <= 1'b0;
      r_par_fail <= 1'b0;
    end else if (i_clear) begin
      r_acc      <= 1'b0;
      r_par_fail <= 1'b0;
    end else begin
      if (i_accum) begin
        r_acc <= r_acc ^ i_bit;
      end
      if (i_check && (i_bit != w_expected)) begin
        r_par_fail <= 1'b1;
      end
    end
  end

  assign o_par_fail = r_par_fail;

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: deserializes LSB-first data, checks parity and stop bit,
// and emits one registered result pulse per frame.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  uart_rx_frame_check_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par_en;
  logic             r_par_type;
  logic [WIDTH-1:0] r_p_data;
  logic             r_data_valid;
  logic             r_par_err;
  logic             r_stp_err;
  logic             r_busy;

  logic w_start;
  logic w_accum;
  logic w_check;
  logic w_par_fail;

  assign w_start = bus.bit_strobe && (r_state == IDLE) && !bus.rx_bit;
  assign w_accum = bus.bit_strobe && (r_state == DATA);
  assign w_check = bus.bit_strobe && (r_state == PARITY);

  uart_rx_par_chk u_par_chk (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_start),
    .i_accum    (w_accum),
    .i_check    (w_check),
    .i_bit      (bus.rx_bit),
    .i_par_type (r_par_type),
    .o_par_fail (w_par_fail)
  );

  // Frame FSM; everything advances only on a bit strobe, result pulses self-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_shift      <= {WIDTH{1'b0}};
      r_par_en     <= 1'b0;
      r_par_type   <= PAR_EVEN;
      r_p_data     <= {WIDTH{1'b0}};
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      if (bus.bit_strobe) begin
        case (r_state)
          IDLE: begin
            if (!bus.rx_bit) begin
              r_state    <= DATA;
              r_cnt      <= {CNT_W{1'b0}};
              r_shift    <= {WIDTH{1'b0}};
              r_par_en   <= bus.par_en;
              r_par_type <= bus.par_type;
              r_busy     <= 1'b1;
            end
          end
          DATA: begin
            r_shift <= {bus.rx_bit, r_shift[WIDTH-1:1]};
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_cnt   <= {CNT_W{1'b0}};
              r_state <= r_par_en ? PARITY : STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PARITY: begin
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (bus.rx_bit && !w_par_fail) begin
              r_data_valid <= 1'b1;
              r_p_data     <= r_shift;
            end else begin
              r_par_err <= w_par_fail;
              r_stp_err <= ~bus.rx_bit;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.p_data     = r_p_data;
  assign bus.data_valid = r_data_valid;
  assign bus.par_err    = r_par_err;
  assign bus.stp_err    = r_stp_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scoreboard bench for uart_rx_frame_check: directed frames push expected results,
// a negedge monitor pops and compares whenever a result pulse appears.
module tb_uart_rx_frame_check;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_frame_check_if #(.WIDTH(8)) bus ();

  uart_rx_frame_check #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } res_t;

  res_t       exp_q[$];
  res_t       mon_exp;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] last_good;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any result pulse must match the oldest expected frame result.
  always @(negedge clk) begin
    if (rst && (bus.data_valid || bus.par_err || bus.stp_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, bus.data_valid, bus.par_err, bus.stp_err}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("data_valid", 32'(bus.data_valid), 32'(mon_exp.dv));
        chk("par_err",    32'(bus.par_err),    32'(mon_exp.pe));
        chk("stp_err",    32'(bus.stp_err),    32'(mon_exp.se));
        chk("p_data",     32'(bus.p_data),     32'(mon_exp.data));
      end
    end
  end

  task automatic strobe(input logic b);
    @(negedge clk);
    bus.bit_strobe = 1'b1;
    bus.rx_bit     = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.bit_strobe = 1'b0;
      bus.rx_bit     = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                            input logic pbit, input logic stopb, input logic exp_good,
                            input logic exp_perr, input logic flip, input int gap);
    res_t e;
    bus.par_en   = pen;
    bus.par_type = ptype;
    strobe(1'b0);
    for (int i = 0; i < 8; i++) begin
      strobe(d[i]);
      if (flip && i == 3) begin
        bus.par_type = ~ptype;
        bus.par_en   = ~pen;
      end
      if (gap > 0) idle(gap);
    end
    if (pen) strobe(pbit);
    e.dv   = exp_good;
    e.pe   = exp_perr;
    e.se   = ~stopb;
    e.data = exp_good ? d : last_good;
    if (exp_good) last_good = d;
    exp_q.push_back(e);
    strobe(stopb);
    chk("busy_in_frame", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    bus.bit_strobe = 1'b0;
    bus.rx_bit     = 1'b1;
    bus.par_en     = 1'b0;
    bus.par_type   = PAR_EVEN;
    last_good      = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_p_data",     32'(bus.p_data),     32'd0);
    chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_par_err",    32'(bus.par_err),    32'd0);
    chk("rst_stp_err",    32'(bus.stp_err),    32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    rst = 1'b1;
    idle(2);

    // Even parity 0xA5 (four ones -> parity bit 0): good frame.
    send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    idle(2);

    // Odd parity 0xA5 with parity bit 0 (expected 1), idle gaps between bits.
    send_frame(8'hA5, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    idle(2);

    // No parity, 0x3C, stop bit 0: stop error only; busy drops after 10 strobes.
    send_frame(8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(1);
    chk("busy_after_stop", 32'(bus.busy), 32'd0);
    idle(1);

    // Both errors: 0x3C even parity expects 0, send 1, and stop 0.
    send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(2);

    // Back-to-back even frames 0x01 (parity 1) and 0xFE (parity 1).
    send_frame(8'h01, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'hFE, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    idle(2);
    chk("b2b_p_data", 32'(bus.p_data), 32'h0000_00FE);

    // Reset after the 4th data bit of a frame; partial frame is dropped.
    bus.par_en   = 1'b1;
    bus.par_type = PAR_EVEN;
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    @(negedge clk);
    bus.bit_strobe = 1'b0;
    rst            = 1'b0;
    #1;
    chk("midrst_busy",   32'(bus.busy),   32'd0);
    chk("midrst_p_data", 32'(bus.p_data), 32'd0);
    last_good = 8'h00;
    idle(2);
    rst = 1'b1;
    idle(2);
    send_frame(8'h55, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    idle(2);
    chk("after_rst_p_data", 32'(bus.p_data), 32'h0000_0055);

    // Idle line: strobes with rx_bit=1 never start a frame.
    for (int i = 0; i < 6; i++) begin
      strobe(1'b1);
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end
    idle(1);
    chk("idle_busy_end", 32'(bus.busy),   32'd0);
    chk("idle_p_data",   32'(bus.p_data), 32'h0000_0055);
    idle(1);

    // Odd parity 0x0F (four ones -> parity bit 1); par_type/par_en flipped mid-frame.
    send_frame(8'h0F, 1'b1, PAR_ODD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    idle(5);
    chk("final_p_data", 32'(bus.p_data), 32'h0000_000F);
    chk("queue_empty",  32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
